// File: rtl/mem_1r1w_ctrl_pkg.sv
// Shared definitions for the 1R1W memory controller.
// Holds the controller state encoding, the default geometry constants and a
// range-check helper used by both the read and the write paths.
package mem_1r1w_ctrl_pkg;

  localparam int DEFAULT_DEPTH = 48;
  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_AW    = 6;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // The address field can encode values beyond the last real word, so every
  // access is range-checked before it may reach the memory macro.
  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_1r1w_ctrl_if.sv
// Client-side bus of the 1R1W memory controller.
//   rd_valid/rd_ready[1:0], rd_addr0/rd_addr1 : two read request clients
//   rsp_valid/rsp_id/rsp_data/rsp_err         : read response (no backpressure)
//   wr_valid/wr_ready/wr_addr/wr_data         : single write client
// master = the clients, slave = the controller.
interface mem_1r1w_ctrl_if
  import mem_1r1w_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = DEFAULT_AW
);

  logic [1:0]       rd_valid;
  logic [1:0]       rd_ready;
  logic [AW-1:0]    rd_addr0;
  logic [AW-1:0]    rd_addr1;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output rd_valid, rd_addr0, rd_addr1, wr_valid, wr_addr, wr_data,
    input  rd_ready, rsp_valid, rsp_id, rsp_data, rsp_err, wr_ready
  );

  modport slave (
    input  rd_valid, rd_addr0, rd_addr1, wr_valid, wr_addr, wr_data,
    output rd_ready, rsp_valid, rsp_id, rsp_data, rsp_err, wr_ready
  );

endinterface

// File: rtl/mem_1r1w_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
//   clock, reset_n : clock and synchronous active-low reset
//   req[1:0]       : requests
//   grant[1:0]     : one-hot (or zero) grant, combinational from req/pointer
//   advance        : a grant was consumed; move the pointer past the winner
// After reset the pointer favours client 0.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  input  logic       advance
);

  // 0: client 0 wins a tie, 1: client 1 wins a tie.
  logic prio_q;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path can leave a value held (no latch inferred).
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking '<=' so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else if (advance) begin
      // Whoever just won drops to lowest priority.
      prio_q <= grant[0];
    end
  end

endmodule

// File: rtl/mem_1r1w_ctrl.sv
// Controller in front of a single-port-read / single-port-write memory macro.
//   clock, reset_n : sole clock (also clocks the macro) and sync active-low reset
//   bus            : client bus (two read clients, responses, one write client)
//   clear          : pulse in RUN restarts the zero-fill of all entries
//   init_done      : high while not zero-filling
//   R0_addr/R0_en/R0_data : macro read port, data returned one cycle after enable
//   W0_addr/W0_en/W0_data : macro write port
// After reset (or clear) the controller spends exactly DEPTH cycles writing
// zeros, then serves round-robin reads and unconditional writes.
module mem_1r1w_ctrl
  import mem_1r1w_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mem_1r1w_ctrl_if.slave       bus,
  input  logic                 clear,
  output logic                 init_done,
  output logic [AW-1:0]        R0_addr,
  output logic                 R0_en,
  input  logic [WIDTH-1:0]     R0_data,
  output logic [AW-1:0]        W0_addr,
  output logic                 W0_en,
  output logic [WIDTH-1:0]     W0_data
);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          in_run;

  logic [1:0]    rd_req, rd_grant;
  logic          rd_fire, rd_in_range;
  logic [AW-1:0] rd_addr;
  logic          wr_fire, wr_in_range;
  logic          byp_hit;

  logic             rsp_valid_q, rsp_id_q, rsp_err_q, byp_q;
  logic [WIDTH-1:0] byp_data_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        // clear is deliberately not looked at here: a fill in progress runs
        // to completion instead of restarting.
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------- Read arbitration ----------------
  assign in_run = (state_q == ST_RUN);
  assign rd_req = bus.rd_valid & {2{in_run}};

  rr_arb2 u_rr_arb2 (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (rd_req),
    .grant   (rd_grant),
    .advance (rd_fire)
  );

  assign rd_fire     = |rd_grant;
  assign rd_addr     = rd_grant[1] ? bus.rd_addr1 : bus.rd_addr0;
  assign rd_in_range = addr_in_range(32'(rd_addr), DEPTH);
  assign wr_fire     = in_run && bus.wr_valid;
  assign wr_in_range = addr_in_range(32'(bus.wr_addr), DEPTH);

  // A read and a write to the same word in one cycle: the macro would return
  // the old contents, so the new write data is captured and returned instead.
  assign byp_hit = rd_fire && rd_in_range && wr_fire && wr_in_range &&
                   (bus.wr_addr == rd_addr);

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.rd_ready = rd_grant;
    bus.wr_ready = in_run;
    init_done    = in_run;
    R0_en        = rd_fire && rd_in_range;
    R0_addr      = rd_addr;
    W0_en        = 1'b0;
    W0_addr      = bus.wr_addr;
    W0_data      = bus.wr_data;
    if (!in_run) begin
      W0_en   = 1'b1;
      W0_addr = cnt_q;
      W0_data = '0;
    end else begin
      // Out-of-range writes are accepted but never reach the macro.
      W0_en = wr_fire && wr_in_range;
    end
  end

  // ---------------- Response pipeline ----------------
  // Independent of the FSM state, so a read accepted in the same cycle as a
  // clear still gets its response; only reset discards it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      byp_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rd_fire;
      rsp_id_q    <= rd_grant[1];
      rsp_err_q   <= rd_fire && !rd_in_range;
      byp_q       <= byp_hit;
    end
  end

  // NOTE: pure datapath storage gets no reset; it is only ever read while its
  // qualifying flag (byp_q) is set, and that flag is reset.
  always_ff @(posedge clock) begin
    if (byp_hit) begin
      byp_data_q <= bus.wr_data;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = (!rsp_valid_q || rsp_err_q) ? '0 :
                         byp_q ? byp_data_q : R0_data;

endmodule

// File: tb/tb_mem_1r1w_ctrl.sv
// Directed testbench for mem_1r1w_ctrl with a behavioural model of the
// attached memory macro (one-cycle read latency, old data on read/write
// collision).
module tb_mem_1r1w_ctrl;
  import mem_1r1w_ctrl_pkg::*;

  localparam int DEPTH = 48;
  localparam int WIDTH = 64;
  localparam int AW    = 6;

  logic             clock;
  logic             reset_n;
  logic             clear;
  logic             init_done;
  logic [AW-1:0]    R0_addr;
  logic             R0_en;
  logic [WIDTH-1:0] R0_data;
  logic [AW-1:0]    W0_addr;
  logic             W0_en;
  logic [WIDTH-1:0] W0_data;

  mem_1r1w_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  mem_1r1w_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .clear     (clear),
    .init_done (init_done),
    .R0_addr   (R0_addr),
    .R0_en     (R0_en),
    .R0_data   (R0_data),
    .W0_addr   (W0_addr),
    .W0_en     (W0_en),
    .W0_data   (W0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory macro model.
  logic [WIDTH-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA5A5_A5A5_A5A5_A5A5;
    R0_data = '0;
  end
  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) R0_data <= mem[R0_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    clear        = 1'b0;
    bus.rd_valid = 2'b00;
    bus.rd_addr0 = '0;
    bus.rd_addr1 = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;

    // ---- Reset state ----
    tick();
    tick();
    settle();
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_rsp_data", bus.rsp_data, 64'd0);
    check("rst_w0_en", 64'(W0_en), 64'd1);
    check("rst_w0_addr", 64'(W0_addr), 64'd0);

    // ---- Zero-fill after reset release; requests must be ignored ----
    reset_n      = 1'b1;
    bus.rd_valid = 2'b11;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd9;
    bus.wr_data  = 64'hFFFF;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      check("init_w0_en", 64'(W0_en), 64'd1);
      check("init_w0_addr", 64'(W0_addr), 64'(i));
      check("init_w0_data", W0_data, 64'd0);
      check("init_done_low", 64'(init_done), 64'd0);
      check("init_rd_ready", 64'(bus.rd_ready), 64'd0);
      check("init_wr_ready", 64'(bus.wr_ready), 64'd0);
      tick();
    end
    bus.rd_valid = 2'b00;
    bus.wr_valid = 1'b0;
    settle();
    check("init_done_high", 64'(init_done), 64'd1);
    check("run_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("mem0_zeroed", mem[0], 64'd0);
    check("mem47_zeroed", mem[47], 64'd0);

    // ---- Seed addresses 5 and 7 ----
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd5;
    bus.wr_data  = 64'h55;
    tick();
    bus.wr_addr  = 6'd7;
    bus.wr_data  = 64'h77;
    tick();
    bus.wr_valid = 1'b0;

    // ---- Round-robin: both valid, grants 0,1,0,1 ----
    bus.rd_addr0 = 6'd5;
    bus.rd_addr1 = 6'd7;
    bus.rd_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rr_ready", 64'(bus.rd_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_r0_en", 64'(R0_en), 64'd1);
      check("rr_r0_addr", 64'(R0_addr), (k % 2 == 0) ? 64'd5 : 64'd7);
      tick();
      check("rr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("rr_rsp_id", 64'(bus.rsp_id), 64'(k % 2));
      check("rr_rsp_data", bus.rsp_data, (k % 2 == 0) ? 64'h55 : 64'h77);
      check("rr_rsp_err", 64'(bus.rsp_err), 64'd0);
    end
    bus.rd_valid = 2'b00;
    tick();
    check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // ---- Write 10 then read 10 ----
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd10;
    bus.wr_data  = 64'hDEAD_BEEF;
    settle();
    check("wr10_w0_en", 64'(W0_en), 64'd1);
    check("wr10_w0_addr", 64'(W0_addr), 64'd10);
    check("wr10_w0_data", W0_data, 64'hDEAD_BEEF);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 2'b01;
    bus.rd_addr0 = 6'd10;
    tick();
    bus.rd_valid = 2'b00;
    check("rd10_valid", 64'(bus.rsp_valid), 64'd1);
    check("rd10_data", bus.rsp_data, 64'hDEAD_BEEF);

    // ---- Same-cycle write/read addr 3 (client 1): bypass ----
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd3;
    bus.wr_data  = 64'h1234;
    bus.rd_valid = 2'b10;
    bus.rd_addr1 = 6'd3;
    settle();
    check("byp_ready", 64'(bus.rd_ready), 64'd2);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 2'b00;
    check("byp_valid", 64'(bus.rsp_valid), 64'd1);
    check("byp_id", 64'(bus.rsp_id), 64'd1);
    check("byp_data", bus.rsp_data, 64'h1234);

    // ---- Out-of-range read 50 and write 63 ----
    bus.rd_valid = 2'b01;
    bus.rd_addr0 = 6'd50;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd63;
    bus.wr_data  = 64'hBAD;
    settle();
    check("oor_rd_ready", 64'(bus.rd_ready), 64'd1);
    check("oor_r0_en", 64'(R0_en), 64'd0);
    check("oor_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("oor_w0_en", 64'(W0_en), 64'd0);
    tick();
    bus.rd_valid = 2'b00;
    bus.wr_valid = 1'b0;
    check("oor_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("oor_rsp_err", 64'(bus.rsp_err), 64'd1);
    check("oor_rsp_data", bus.rsp_data, 64'd0);
    tick();
    check("oor_after_valid", 64'(bus.rsp_valid), 64'd0);
    check("oor_after_err", 64'(bus.rsp_err), 64'd0);

    // ---- Write 20, then clear together with a read of 20 ----
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd20;
    bus.wr_data  = 64'hABCD;
    tick();
    bus.wr_valid = 1'b0;
    clear        = 1'b1;
    bus.rd_valid = 2'b01;
    bus.rd_addr0 = 6'd20;
    settle();
    check("clr_rd_ready", 64'(bus.rd_ready), 64'd1);
    tick();
    clear        = 1'b0;
    check("clr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("clr_rsp_data", bus.rsp_data, 64'hABCD);
    // Re-fill: a second clear pulse mid-fill must not restart it.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) clear = 1'b1;
      settle();
      check("refill_w0_addr", 64'(W0_addr), 64'(i));
      check("refill_done_low", 64'(init_done), 64'd0);
      check("refill_rd_ready", 64'(bus.rd_ready), 64'd0);
      if (i == 1) check("refill_no_rsp", 64'(bus.rsp_valid), 64'd0);
      tick();
      clear = 1'b0;
    end
    bus.rd_valid = 2'b00;
    settle();
    check("refill_done_high", 64'(init_done), 64'd1);
    bus.rd_valid = 2'b01;
    bus.rd_addr0 = 6'd20;
    tick();
    bus.rd_valid = 2'b00;
    check("rd20_valid", 64'(bus.rsp_valid), 64'd1);
    check("rd20_zero", bus.rsp_data, 64'd0);

    // ---- Reset mid-RUN with a read accepted: response discarded ----
    bus.rd_valid = 2'b01;
    bus.rd_addr0 = 6'd5;
    reset_n      = 1'b0;
    tick();
    bus.rd_valid = 2'b00;
    check("rstrun_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rstrun_rsp_data", bus.rsp_data, 64'd0);
    check("rstrun_init_done", 64'(init_done), 64'd0);
    check("rstrun_w0_addr", 64'(W0_addr), 64'd0);

    // ---- Reset mid-INIT restarts the fill from 0 ----
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("midinit_w0_addr", 64'(W0_addr), 64'd5);
    reset_n = 1'b0;
    tick();
    check("midinit_rst_addr", 64'(W0_addr), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("reinit_w0_addr", 64'(W0_addr), 64'(i));
      tick();
    end
    check("reinit_done", 64'(init_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
